// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matrix-multiply tile scheduler.
//   - state_t       : scheduler FSM encoding
//   - TILE/MAX_DIM  : tile edge and largest supported matrix dimension
//   - A_BASE/B_BASE : address-region bases for A and B tiles
//   - grid_of()     : tiles per matrix edge for a given dim (0 = illegal dim)
//   - jobs_of()     : total tile jobs (G^3) for a grid size
package matmul_pkg;

  localparam int TILE     = 4;
  localparam int MAX_DIM  = 8;
  localparam int GRID_MAX = MAX_DIM / TILE;

  localparam logic [3:0] DIM_TILE = 4'(TILE);
  localparam logic [3:0] DIM_MAX  = 4'(MAX_DIM);

  localparam logic [3:0] A_BASE = 4'b0000;
  localparam logic [3:0] B_BASE = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Grid edge in tiles; 0 flags a dimension the datapath cannot handle.
  function automatic logic [1:0] grid_of(input logic [3:0] dim);
    if (dim == 4'd0 || dim > DIM_MAX) return 2'd0;
    else if (dim <= DIM_TILE)         return 2'd1;
    else                              return 2'd2;
  endfunction

  function automatic logic [3:0] jobs_of(input logic [1:0] g);
    return (g == 2'd2) ? 4'd8 : 4'd1;
  endfunction

endpackage

// File: rtl/matmul_tile_sched_idx.sv
// tile_idx_counter: nested (i,j,k) tile-index counter, k innermost.
//   clk, rstn  : clock, async active-low reset
//   clr_i      : restart at (0,0,0)
//   adv_i      : step to the next (i,j,k) triple, wrapping after the last
//   grid_i     : grid edge G (indices run 0..G-1)
//   i_o/j_o/k_o: current indices
//   first_k_o  : k == 0
//   last_k_o   : k == G-1
//   wrap_o     : current triple is the final one of the product
module tile_idx_counter #(
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [IDX_W:0]   grid_i,
  output logic [IDX_W-1:0] i_o,
  output logic [IDX_W-1:0] j_o,
  output logic [IDX_W-1:0] k_o,
  output logic             first_k_o,
  output logic             last_k_o,
  output logic             wrap_o
);

  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic [IDX_W-1:0] i_d, j_d, k_d;
  logic [IDX_W-1:0] top;

  // Highest legal index for this grid.
  assign top = IDX_W'(grid_i - 1'b1);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      if (k_q != top) begin
        k_d = k_q + 1'b1;
      end else begin
        k_d = '0;
        if (j_q != top) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          i_d = (i_q != top) ? i_q + 1'b1 : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_o       = i_q;
  assign j_o       = j_q;
  assign k_o       = k_q;
  assign first_k_o = (k_q == '0);
  assign last_k_o  = (k_q == top);
  assign wrap_o    = (i_q == top) && (j_q == top) && (k_q == top);

endmodule

// File: rtl/matmul_tile_sched.sv
// matmul_tile_sched: turns one "multiply NxN" command into 4x4 tile jobs for
// the MAC engine, throttles outstanding jobs and reports completion.
//   clk, rstn        : clock, async active-low reset
//   start_i, dim_i   : command strobe and dimension (taken only in IDLE)
//   job_valid_o/ready: job handshake to the engine
//   job_a_addr_o     : A tile {2'b00,i,k}; job_b_addr_o: B tile {2'b10,k,j}
//   job_c_idx_o      : C tile {i,j}
//   job_acc_clr_o    : first k-step of a C tile
//   job_acc_last_o   : last k-step of a C tile
//   job_done_i       : one pulse per completed job, in issue order
//   busy_o           : command in flight
//   all_finish_o     : single pulse once every job has completed
//   err_o            : pulse on illegal dim or a done with nothing outstanding
module matmul_tile_sched
  import matmul_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_i,
  input  logic [3:0] dim_i,
  output logic       job_valid_o,
  input  logic       job_ready_i,
  output logic [3:0] job_a_addr_o,
  output logic [3:0] job_b_addr_o,
  output logic [1:0] job_c_idx_o,
  output logic       job_acc_clr_o,
  output logic       job_acc_last_o,
  input  logic       job_done_i,
  output logic       busy_o,
  output logic       all_finish_o,
  output logic       err_o
);

  localparam logic [1:0] OUTST_MAX = 2'(MAX_OUTST);

  state_t     state_q, state_d;
  logic [1:0] grid_q, grid_d;
  logic [3:0] total_q, total_d;
  logic [1:0] outst_q, outst_d;
  logic [3:0] done_cnt_q, done_cnt_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic [1:0] grid_req;
  logic       start_ok, start_bad;
  logic       xfer, done_ok, done_bad;
  logic       ii, jj, kk, first_k, last_k, wrap;
  logic       in_issue;

  assign grid_req  = grid_of(dim_i);
  assign start_ok  = start_i && (state_q == IDLE) && (grid_req != 2'd0);
  assign start_bad = start_i && (state_q == IDLE) && (grid_req == 2'd0);
  assign xfer      = valid_q && job_ready_i;
  // A done with nothing outstanding is a protocol error and is dropped.
  assign done_ok   = job_done_i && (outst_q != 2'd0);
  assign done_bad  = job_done_i && (outst_q == 2'd0);

  tile_idx_counter #(.IDX_W(1)) u_idx (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (start_ok),
    .adv_i     (xfer),
    .grid_i    (grid_q),
    .i_o       (ii),
    .j_o       (jj),
    .k_o       (kk),
    .first_k_o (first_k),
    .last_k_o  (last_k),
    .wrap_o    (wrap)
  );

  always_comb begin
    state_d    = state_q;
    grid_d     = grid_q;
    total_d    = total_q;
    outst_d    = outst_q;
    done_cnt_d = done_cnt_q;
    err_d      = start_bad || done_bad;

    if (start_ok) begin
      outst_d    = 2'd0;
      done_cnt_d = 4'd0;
    end else begin
      if (xfer && !done_ok)      outst_d = outst_q + 2'd1;
      else if (!xfer && done_ok) outst_d = outst_q - 2'd1;
      if (done_ok)               done_cnt_d = done_cnt_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          grid_d  = grid_req;
          total_d = jobs_of(grid_req);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer && wrap) state_d = DRAIN;
      end
      // Look at the post-update count so the finish pulse lands the cycle
      // right after the final done.
      DRAIN: begin
        if (done_cnt_d == total_q) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered valid: drops the cycle after the window fills unless a done
    // frees a slot in the same cycle; only falls after a transfer.
    valid_d = (state_d == ISSUE) && (outst_d < OUTST_MAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grid_q     <= 2'd0;
      total_q    <= 4'd0;
      outst_q    <= 2'd0;
      done_cnt_q <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grid_q     <= grid_d;
      total_q    <= total_d;
      outst_q    <= outst_d;
      done_cnt_q <= done_cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Job fields come straight from the index registers, so they only move on
  // a transfer; they read as zero outside ISSUE.
  assign in_issue       = (state_q == ISSUE);
  assign job_valid_o    = valid_q;
  assign job_a_addr_o   = in_issue ? (A_BASE | {2'b00, ii, kk}) : 4'd0;
  assign job_b_addr_o   = in_issue ? (B_BASE | {2'b00, kk, jj}) : 4'd0;
  assign job_c_idx_o    = in_issue ? {ii, jj} : 2'd0;
  assign job_acc_clr_o  = in_issue && first_k;
  assign job_acc_last_o = in_issue && last_k;
  assign busy_o         = (state_q != IDLE);
  assign all_finish_o   = (state_q == FIN);
  assign err_o          = err_q;

endmodule

// File: tb/tb_matmul_tile_sched.sv
module tb_matmul_tile_sched;

  typedef struct {
    string nm;
    int    act;
    int    exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [3:0] dim;
  logic       job_valid;
  logic       job_ready;
  logic [3:0] job_a_addr;
  logic [3:0] job_b_addr;
  logic [1:0] job_c_idx;
  logic       job_acc_clr;
  logic       job_acc_last;
  logic       job_done = 1'b0;
  logic       busy;
  logic       all_finish;
  logic       err;

  always #5 clk = ~clk;

  matmul_tile_sched dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start),
    .dim_i          (dim),
    .job_valid_o    (job_valid),
    .job_ready_i    (job_ready),
    .job_a_addr_o   (job_a_addr),
    .job_b_addr_o   (job_b_addr),
    .job_c_idx_o    (job_c_idx),
    .job_acc_clr_o  (job_acc_clr),
    .job_acc_last_o (job_acc_last),
    .job_done_i     (job_done),
    .busy_o         (busy),
    .all_finish_o   (all_finish),
    .err_o          (err)
  );

  // Scoreboard of expected jobs {a,b,c,clr,last}, check requests, done schedule.
  logic [11:0] sb[$];
  chk_t        cq[$];
  int          dq[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int xfer_cnt = 0, fin_cnt = 0, err_cnt = 0, valid_cnt = 0, busy_cnt = 0;
  int fin_cyc = 0, done_cyc = 0;
  int man_req = 0, man_srv = 0;
  int done_dly = 0;
  bit done_en = 1'b1;
  bit rnd_mode = 1'b0;
  bit rdy_fix = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    job_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  always @(posedge clk) begin
    #1;
    job_done = 1'b0;
    if (man_req > man_srv) begin
      man_srv  = man_srv + 1;
      job_done = 1'b1;
    end else if (dq.size() != 0 && dq[0] <= cyc) begin
      void'(dq.pop_front());
      job_done = 1'b1;
    end
  end

  // Monitor: all comparisons happen here.
  logic [11:0] prev_f;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    chk_t        c;
    logic [11:0] f, e;
    while (cq.size() != 0) begin
      c = cq.pop_front();
      n_cmp = n_cmp + 1;
      if (c.act != c.exp) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %0d expected %0d", c.nm, c.act, c.exp);
      end
    end
    f = {job_a_addr, job_b_addr, job_c_idx, job_acc_clr, job_acc_last};
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp = n_cmp + 1;
        if (!job_valid || f != prev_f) begin
          n_err = n_err + 1;
          $display("FAIL stall_hold: got v=%0b f=%h expected v=1 f=%h", job_valid, f, prev_f);
        end
      end
      if (job_valid && job_ready) begin
        xfer_cnt = xfer_cnt + 1;
        n_cmp = n_cmp + 1;
        if (sb.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL extra_job: got f=%h expected no job", f);
        end else begin
          e = sb.pop_front();
          if (f != e) begin
            n_err = n_err + 1;
            $display("FAIL job_fields: got %h expected %h", f, e);
          end
        end
        if (done_en) dq.push_back(cyc + 1 + done_dly);
      end
      prev_stall = job_valid && !job_ready;
      prev_f     = f;
      if (all_finish) begin fin_cnt = fin_cnt + 1; fin_cyc = cyc; end
      if (err)        err_cnt = err_cnt + 1;
      if (job_done)   done_cyc = cyc;
      if (job_valid)  valid_cnt = valid_cnt + 1;
      if (busy)       busy_cnt = busy_cnt + 1;
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    cq.push_back('{nm, act, exp});
  endfunction

  function automatic int outs_packed();
    return int'({job_valid, job_a_addr, job_b_addr, job_c_idx, job_acc_clr,
                 job_acc_last, busy, all_finish, err});
  endfunction

  function automatic void push_g1();
    sb.push_back({4'd0, 4'd8, 2'd0, 1'b1, 1'b1});
  endfunction

  function automatic void push_g2();
    sb.push_back({4'd0, 4'd8,  2'd0, 1'b1, 1'b0});
    sb.push_back({4'd1, 4'd10, 2'd0, 1'b0, 1'b1});
    sb.push_back({4'd0, 4'd9,  2'd1, 1'b1, 1'b0});
    sb.push_back({4'd1, 4'd11, 2'd1, 1'b0, 1'b1});
    sb.push_back({4'd2, 4'd8,  2'd2, 1'b1, 1'b0});
    sb.push_back({4'd3, 4'd10, 2'd2, 1'b0, 1'b1});
    sb.push_back({4'd2, 4'd9,  2'd3, 1'b1, 1'b0});
    sb.push_back({4'd3, 4'd11, 2'd3, 1'b0, 1'b1});
  endfunction

  task automatic go(input logic [3:0] d);
    @(posedge clk); #1;
    start = 1'b1;
    dim   = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fin(input string nm, output int lo);
    int base;
    bit got;
    base = fin_cnt;
    got  = 1'b0;
    lo   = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk); #1;
      if (!busy) lo++;
      if (fin_cnt > base) got = 1'b1;
    end
    chk({nm, "_finish"}, int'(got), 1);
  endtask

  initial begin
    int lo, x0, e0, v0, b0;
    rstn  = 1'b0;
    start = 1'b0;
    dim   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_packed(), 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // dim=3: single job, done two cycles later
    rdy_fix = 1'b1; done_dly = 1; done_en = 1'b1;
    push_g1();
    x0 = xfer_cnt;
    go(4'd3);
    wait_fin("g1", lo);
    chk("g1_busy_low_cycles", lo, 0);
    chk("g1_finish_after_done", fin_cyc - done_cyc, 1);
    chk("g1_xfers", xfer_cnt - x0, 1);
    chk("g1_sb_empty", sb.size(), 0);
    @(negedge clk); #1;
    chk("g1_idle_busy", int'(busy), 0);

    // dim=8, immediate done, plus a start during ISSUE that must be ignored
    done_dly = 0;
    push_g2();
    x0 = xfer_cnt;
    go(4'd8);
    @(posedge clk); #1;
    start = 1'b1; dim = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_fin("g2", lo);
    chk("g2_busy_low_cycles", lo, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("g2_xfers", xfer_cnt - x0, 8);
    chk("g2_sb_empty", sb.size(), 0);
    chk("g2_no_restart", int'(busy), 0);

    // done withheld: outstanding window of 2
    done_en = 1'b0;
    push_g2();
    x0 = xfer_cnt;
    go(4'd8);
    repeat (10) @(negedge clk);
    #1;
    chk("hold_xfers", xfer_cnt - x0, 2);
    chk("hold_valid", int'(job_valid), 0);
    man_req = man_req + 1;
    repeat (10) @(negedge clk);
    #1;
    chk("hold_one_more", xfer_cnt - x0, 3);
    chk("hold_valid2", int'(job_valid), 0);
    done_en = 1'b1;
    man_req = man_req + 2;
    wait_fin("hold", lo);
    chk("hold_xfers_total", xfer_cnt - x0, 8);
    chk("hold_sb_empty", sb.size(), 0);

    // random ready with stall stability checks in the monitor
    done_dly = 2;
    rnd_mode = 1'b1;
    push_g2();
    x0 = xfer_cnt;
    go(4'd8);
    wait_fin("rnd", lo);
    rnd_mode = 1'b0;
    chk("rnd_xfers", xfer_cnt - x0, 8);
    chk("rnd_sb_empty", sb.size(), 0);

    // illegal dims
    e0 = err_cnt; v0 = valid_cnt; b0 = busy_cnt;
    go(4'd0);
    repeat (4) @(negedge clk);
    #1;
    chk("dim0_err", err_cnt - e0, 1);
    chk("dim0_busy", busy_cnt - b0, 0);
    chk("dim0_valid", valid_cnt - v0, 0);
    e0 = err_cnt; v0 = valid_cnt; b0 = busy_cnt;
    go(4'd9);
    repeat (4) @(negedge clk);
    #1;
    chk("dim9_err", err_cnt - e0, 1);
    chk("dim9_busy", busy_cnt - b0, 0);
    chk("dim9_valid", valid_cnt - v0, 0);

    // reset in the middle of ISSUE after three transfers
    done_dly = 0;
    push_g2();
    x0 = xfer_cnt;
    go(4'd8);
    for (int c = 0; c < 50 && (xfer_cnt - x0) < 3; c++) begin
      @(negedge clk); #1;
    end
    chk("rst_pre_xfers", xfer_cnt - x0, 3);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("rst_async_outputs", outs_packed(), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    push_g2();
    x0 = xfer_cnt;
    go(4'd5);
    wait_fin("replay", lo);
    chk("replay_xfers", xfer_cnt - x0, 8);
    chk("replay_sb_empty", sb.size(), 0);

    chk("err_total", err_cnt, 2);
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
